dmem_dump_reader: RTL and testbench

Sequential data-memory reader used at the end of a core test run: once the program has finished, it walks a contiguous window of the data memory through the memory's synchronous read port and streams every word out over a valid/ready interface to the checking side of the bench or a debug link. It is the read-back counterpart to the program/data preload path: that path fills memory before a run, and this block drains results after it.

---
 rtl/dmem_dump_reader.sv | 149 ++++++++++++++
 tb/tb_dmem_dump_reader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_dump_reader.sv
// Post-run data-memory dump: reads a contiguous word window through the memory's
// synchronous read port and streams it out. Optional trailing checksum word: DMEM_DUMP_CHECKSUM_EN.
module dmem_dump_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        CAPT = 3'd2,
        SEND = 3'd3,
`ifdef DMEM_DUMP_CHECKSUM_EN
        CSUM = 3'd4,
`endif
        FIN  = 3'd5
    } state_t;

    localparam logic [ADDR_W:0] ONE_LEFT = 1;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic              handshake;
`ifdef DMEM_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    // A word transfers on a rising edge where out_valid && out_ready; once out_valid
    // rises, out_valid/out_data/out_last hold until that edge, whatever out_ready does.
    assign handshake = out_valid && out_ready;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
`ifdef DMEM_DUMP_CHECKSUM_EN
            checksum  <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (word_count != '0) begin
                            addr      <= base_addr;
                            remaining <= word_count;
                            mem_re    <= 1'b1;
                            mem_addr  <= base_addr;
                            busy      <= 1'b1;
                            state     <= READ;
`ifdef DMEM_DUMP_CHECKSUM_EN
                            checksum  <= '0;
`endif
                        end else begin
                            // Empty window: finish without touching memory.
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end
                READ: begin
                    mem_re <= 1'b0;
                    state  <= CAPT;
                end
                CAPT: begin
                    out_data  <= mem_rdata;
                    out_valid <= 1'b1;
                    remaining <= remaining - ONE_LEFT;
                    addr      <= addr + 1'b1;
`ifdef DMEM_DUMP_CHECKSUM_EN
                    checksum  <= checksum + mem_rdata;
                    out_last  <= 1'b0;
`else
                    out_last  <= (remaining == ONE_LEFT);
`endif
                    state     <= SEND;
                end
                SEND: begin
                    if (handshake) begin
                        if (remaining != '0) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            mem_re    <= 1'b1;
                            mem_addr  <= addr;
                            state     <= READ;
                        end else begin
`ifdef DMEM_DUMP_CHECKSUM_EN
                            out_valid <= 1'b1;
                            out_data  <= checksum;
                            out_last  <= 1'b1;
                            state     <= CSUM;
`else
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= FIN;
`endif
                        end
                    end
                end
`ifdef DMEM_DUMP_CHECKSUM_EN
                CSUM: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= FIN;
                    end
                end
`endif
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_dump_reader.sv
// Randomised bench for dmem_dump_reader: a word-list model of each dump is compared
// against the stream, the read addresses and the done/busy timing every cycle.
module tb_dmem_dump_reader;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [ADDR_W:0]   cnt_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    addr_t             base_addr = '0;
    cnt_t              word_count = '0;
    logic              busy;
    logic              done;
    logic              mem_re;
    addr_t             mem_addr;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready = 1'b0;
    logic [2:0]        state_dbg;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] exp_q[$];
    addr_t             exp_addr_q[$];

    int tests = 0;
    int fails = 0;
    int words_popped = 0;
    int done_cnt = 0;
    int ready_mode = 0;
    int stall_cnt = 0;
    bit zero_dump = 1'b0;

    logic [DATA_W-1:0] lit_words [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    addr_t             lit_wrap  [4] = '{10'd1022, 10'd1023, 10'd0, 10'd1};

    dmem_dump_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .mem_re     (mem_re),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .state_dbg  (state_dbg)
    );

    // clock / reset and memory model
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // sink driver: always ready, random ready, or five stall cycles per word
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (!out_valid) begin
                    stall_cnt = 0;
                    out_ready = 1'b0;
                end else if (stall_cnt < 5) begin
                    out_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    out_ready = 1'b1;
                    stall_cnt = 0;
                end
            end
        endcase
    end

    // scoreboard: compares every meaningful output cycle against the model queues
    logic              prev_valid = 1'b0;
    logic              prev_hs = 1'b0;
    logic              prev_final = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
            prev_final = 1'b0;
        end else begin
            if (mem_re) begin
                if (exp_addr_q.size() == 0) chk("mem_re_unexpected", {54'd0, mem_addr}, 64'hFFFF);
                else begin
                    chk("mem_addr", {54'd0, mem_addr}, {54'd0, exp_addr_q[0]});
                    void'(exp_addr_q.pop_front());
                end
            end
            if (prev_valid && !prev_hs) begin
                chk("stall_valid_held", {63'd0, out_valid}, 64'd1);
                chk("stall_data_held", {32'd0, out_data}, {32'd0, prev_data});
            end
            if (out_valid) begin
                if (exp_q.size() == 0) chk("valid_unexpected", {32'd0, out_data}, 64'hFFFF_FFFF_FFFF);
                else begin
                    chk("out_data", {32'd0, out_data}, {32'd0, exp_q[0]});
                    chk("out_last", {63'd0, out_last}, {63'd0, exp_q.size() == 1});
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        words_popped++;
                    end
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_busy_low", {63'd0, busy}, 64'd0);
                if (!zero_dump) chk("done_after_last_hs", {63'd0, prev_final}, 64'd1);
            end
            prev_valid = out_valid;
            prev_data  = out_data;
            prev_hs    = out_valid && out_ready;
            prev_final = out_valid && out_ready && out_last;
        end
    end

    // model: the words and addresses a dump of cnt words from base must produce
    task automatic build_model(input addr_t base, input cnt_t cnt);
        logic [DATA_W-1:0] s;
        addr_t a;
        s = '0;
        exp_q.delete();
        exp_addr_q.delete();
        words_popped = 0;
        for (int i = 0; i < int'(cnt); i++) begin
            a = base + addr_t'(i);
            exp_q.push_back(mem[a]);
            exp_addr_q.push_back(a);
            s = s + mem[a];
        end
`ifdef DMEM_DUMP_CHECKSUM_EN
        if (cnt != '0) exp_q.push_back(s);
`endif
        zero_dump = (cnt == '0);
    endtask

    task automatic run_dump(input addr_t base, input cnt_t cnt, input int pin, input bit inject);
        bit seen_done;
        bit injected;
        int done_before;
        build_model(base, cnt);
        if (pin == 1) begin
            for (int i = 0; i < 4; i++) chk("model_word", {32'd0, exp_q[i]}, {32'd0, lit_words[i]});
`ifdef DMEM_DUMP_CHECKSUM_EN
            chk("model_csum", {32'd0, exp_q[4]}, 64'hAAAAAAAA);
`endif
        end
        if (pin == 2) begin
            for (int i = 0; i < 4; i++) chk("model_wrap_addr", {54'd0, exp_addr_q[i]}, {54'd0, lit_wrap[i]});
        end
        done_before = done_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = base;
        word_count = cnt;
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = addr_t'($urandom);
        word_count = cnt_t'($urandom);
        chk("busy_after_start", {63'd0, busy}, {63'd0, cnt != '0});
        chk("mem_re_after_start", {63'd0, mem_re}, {63'd0, cnt != '0});
        chk("done_after_start", {63'd0, done}, {63'd0, cnt == '0});
        if (cnt != '0) begin
            @(posedge clk); #1;
            chk("valid_low_e1", {63'd0, out_valid}, 64'd0);
            @(posedge clk); #1;
            chk("valid_high_e2", {63'd0, out_valid}, 64'd1);
            seen_done = 1'b0;
            injected = 1'b0;
            for (int c = 0; c < 60 * int'(cnt) + 20 && !seen_done; c++) begin
                @(posedge clk); #1;
                start = 1'b0;
                if (done) seen_done = 1'b1;
                else chk("busy_during_dump", {63'd0, busy}, 64'd1);
                if (inject && !injected && words_popped == 1 && out_valid) begin
                    start = 1'b1;
                    base_addr = addr_t'($urandom);
                    word_count = cnt_t'($urandom_range(1, 8));
                    injected = 1'b1;
                end
            end
            chk("done_within_budget", {63'd0, seen_done}, 64'd1);
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulse_count", 64'(done_cnt - done_before), 64'd1);
        chk("model_drained", 64'(exp_q.size() + exp_addr_q.size()), 64'd0);
        chk("idle_busy", {63'd0, busy}, 64'd0);
        chk("idle_valid", {63'd0, out_valid}, 64'd0);
    endtask

    task automatic reset_mid_send(input addr_t base, input cnt_t cnt);
        bit seen_send;
        build_model(base, cnt);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = base;
        word_count = cnt;
        @(posedge clk); #1;
        start = 1'b0;
        seen_send = 1'b0;
        for (int c = 0; c < 40 && !seen_send; c++) begin
            @(posedge clk); #1;
            if (out_valid && words_popped >= 1) seen_send = 1'b1;
        end
        chk("reached_send", {63'd0, seen_send}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_mem_re", {63'd0, mem_re}, 64'd0);
        chk("rst_out_last", {63'd0, out_last}, 64'd0);
        exp_q.delete();
        exp_addr_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[i] = lit_words[i];
        #12;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_mem_re", {63'd0, mem_re}, 64'd0);
        chk("reset_mem_addr", {54'd0, mem_addr}, 64'd0);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_out_data", {32'd0, out_data}, 64'd0);
        chk("reset_out_last", {63'd0, out_last}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        ready_mode = 0;
        run_dump(10'd0, 11'd4, 1, 1'b0);
        ready_mode = 2;
        run_dump(10'd0, 11'd4, 1, 1'b0);
        ready_mode = 0;
        run_dump(10'd1022, 11'd4, 2, 1'b0);
        run_dump(10'd5, 11'd0, 0, 1'b0);
        run_dump(10'd0, 11'd4, 1, 1'b1);
        ready_mode = 1;
        run_dump(10'd300, 11'd6, 0, 1'b1);
        ready_mode = 2;
        reset_mid_send(10'd40, 11'd6);
        ready_mode = 0;
        run_dump(10'd100, 11'd5, 0, 1'b0);

        for (int t = 0; t < 25; t++) begin
            ready_mode = $urandom_range(0, 1);
            for (int k = 0; k < 8; k++) mem[$urandom_range(0, DEPTH - 1)] = $urandom;
            run_dump(addr_t'($urandom), cnt_t'($urandom_range(0, 12)), 0, ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
